// File: rtl/coproc_issue.sv
// Command FIFO and issue sequencer for a register-based coprocessor, with a 4-stage write-back tracker.
// Define ISSUE_HAZARD_STALL_EN to hold the FIFO head on read-after-write hazards against in-flight results.
module coproc_issue #(
    parameter int         DEPTH     = 4,
    parameter logic [5:0] IDLE_ADDR = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [14:0] cmd_data,
    input  logic        flush,
    output logic [5:0]  instr,
    output logic [5:0]  op0_id,
    output logic [2:0]  cmd_id,
    output logic        issue,
    output logic        retire,
    output logic [2:0]  inflight,
    output logic [3:0]  fifo_count,
    output logic        stall
);

    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);
    localparam int         TRK      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_reg;
    logic [14:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [3:0]    count_reg;
    logic [3:0]    count_next;
    logic          ready_en_reg;
    logic [14:0]   head;
    logic          push;
    logic          pop;
    logic          hazard;

    logic [5:0]    instr_reg;
    logic [5:0]    op0_reg;
    logic [2:0]    cmd_reg;
    logic          issue_reg;
    logic          retire_reg;
    logic          trk_valid_reg [TRK];
    logic [2:0]    inflight_sum;

    genvar gi;

    assign head       = mem[rd_ptr_reg];
    assign fifo_count = count_reg;
    // Ready stays low until the first clock edge after reset release.
    assign cmd_ready  = ready_en_reg && (count_reg != FULL_CNT);
    assign push       = cmd_valid && cmd_ready && !flush;
    assign pop        = !flush && (state_reg != IDLE) && (count_reg != 4'd0) && !hazard;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 4'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_reg + 4'd1;
                2'b01:   count_next = count_reg - 4'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= 4'd0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            count_reg    <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else if (flush) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_next != 4'd0) begin
                        state_reg <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (count_next == 4'd0) begin
                        state_reg <= IDLE;
                    end else if (!pop && hazard) begin
                        state_reg <= HOLD;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall = (state_reg == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg <= IDLE_ADDR;
            op0_reg   <= IDLE_ADDR;
            cmd_reg   <= 3'b111;
            issue_reg <= 1'b0;
        end else if (pop) begin
            instr_reg <= head[5:0];
            op0_reg   <= head[11:6];
            cmd_reg   <= head[14:12];
            issue_reg <= 1'b1;
        end else begin
            instr_reg <= IDLE_ADDR;
            op0_reg   <= IDLE_ADDR;
            cmd_reg   <= 3'b111;
            issue_reg <= 1'b0;
        end
    end

    assign instr  = instr_reg;
    assign op0_id = op0_reg;
    assign cmd_id = cmd_reg;
    assign issue  = issue_reg;

    // Stage 0 is loaded on the pop edge, so it shadows the issue cycle itself.
    generate
        for (gi = 0; gi < TRK; gi++) begin : g_trk
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        trk_valid_reg[gi] <= 1'b0;
                    end else begin
                        trk_valid_reg[gi] <= pop;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        trk_valid_reg[gi] <= 1'b0;
                    end else begin
                        trk_valid_reg[gi] <= trk_valid_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_reg <= 1'b0;
        end else begin
            retire_reg <= trk_valid_reg[TRK-1];
        end
    end

    assign retire = retire_reg;

    always_comb begin
        inflight_sum = 3'd0;
        for (int i = 0; i < TRK; i++) begin
            inflight_sum = inflight_sum + {2'b00, trk_valid_reg[i]};
        end
    end

    assign inflight = inflight_sum;

`ifdef ISSUE_HAZARD_STALL_EN
    // The last stage writes back in the cycle the head would issue, where
    // forwarding covers it, so only the first three addresses can block.
    logic [5:0]     trk_addr_reg [TRK-1];
    logic [TRK-2:0] hazard_vec;

    generate
        for (gi = 0; gi < TRK-1; gi++) begin : g_addr
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        trk_addr_reg[gi] <= IDLE_ADDR;
                    end else begin
                        trk_addr_reg[gi] <= pop ? head[5:0] : IDLE_ADDR;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        trk_addr_reg[gi] <= IDLE_ADDR;
                    end else begin
                        trk_addr_reg[gi] <= trk_addr_reg[gi-1];
                    end
                end
            end
            assign hazard_vec[gi] = trk_valid_reg[gi] &&
                                    ((trk_addr_reg[gi] == head[11:6]) ||
                                     (trk_addr_reg[gi] == head[5:0]));
        end
    endgenerate

    assign hazard = |hazard_vec;
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_issue.sv
// Directed self-checking bench for coproc_issue: issue/retire timing, ordering, flush and reset.
// Hazard-stall expectations switch on ISSUE_HAZARD_STALL_EN.
module tb_coproc_issue;

    localparam logic [5:0] TB_IDLE = 6'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_data;
    logic        flush;
    logic [5:0]  instr;
    logic [5:0]  op0_id;
    logic [2:0]  cmd_id;
    logic        issue;
    logic        retire;
    logic [2:0]  inflight;
    logic [3:0]  fifo_count;
    logic        stall;

    int vec_cnt = 0;
    int err_cnt = 0;

    coproc_issue #(
        .DEPTH     (4),
        .IDLE_ADDR (TB_IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .flush      (flush),
        .instr      (instr),
        .op0_id     (op0_id),
        .cmd_id     (cmd_id),
        .issue      (issue),
        .retire     (retire),
        .inflight   (inflight),
        .fifo_count (fifo_count),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [14:0] mk(input logic [2:0] c, input logic [5:0] a, input logic [5:0] b);
        return {c, a, b};
    endfunction

    function automatic logic [14:0] stream(input int i);
        return mk(3'(i), 6'(30 + i), 6'(10 + i));
    endfunction

    task automatic chk_bubble(input string tag);
        chk({tag, ".issue"}, 32'(issue), 32'd0);
        chk({tag, ".instr"}, 32'(instr), 32'(TB_IDLE));
        chk({tag, ".op0"}, 32'(op0_id), 32'(TB_IDLE));
        chk({tag, ".cmd"}, 32'(cmd_id), 32'd7);
    endtask

    task automatic chk_issue(input string tag, input logic [14:0] v);
        chk({tag, ".issue"}, 32'(issue), 32'd1);
        chk({tag, ".cmd"}, 32'(cmd_id), 32'(v[14:12]));
        chk({tag, ".op0"}, 32'(op0_id), 32'(v[11:6]));
        chk({tag, ".instr"}, 32'(instr), 32'(v[5:0]));
    endtask

    initial begin
        logic [14:0] a;
        logic [14:0] b;
        logic [14:0] w;
        logic [14:0] x;
        logic [14:0] y;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        flush     = 1'b0;

        // Held in reset
        repeat (2) tick();
        chk_bubble("rst");
        chk("rst.retire", 32'(retire), 32'd0);
        chk("rst.inflight", 32'(inflight), 32'd0);
        chk("rst.count", 32'(fifo_count), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ready", 32'(cmd_ready), 32'd0);

        reset = 1'b1;
        tick();
        chk("rel.ready", 32'(cmd_ready), 32'd1);
        chk("rel.count", 32'(fifo_count), 32'd0);
        chk_bubble("rel");

        // Single command: issue on the cycle after the pop edge, retire four cycles later
        cmd_valid = 1'b1;
        cmd_data  = 15'h50C3;
        tick();
        cmd_valid = 1'b0;
        chk("single.count", 32'(fifo_count), 32'd1);
        chk("single.pre_issue", 32'(issue), 32'd0);
        tick();
        chk_issue("single", 15'h50C3);
        chk("single.inflight", 32'(inflight), 32'd1);
        chk("single.count0", 32'(fifo_count), 32'd0);
        chk("single.retire_early", 32'(retire), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("single.retire_wait", 32'(retire), 32'd0);
            chk("single.bubble", 32'(issue), 32'd0);
        end
        tick();
        chk("single.retire", 32'(retire), 32'd1);
        chk("single.inflight0", 32'(inflight), 32'd0);
        tick();
        chk("single.retire_off", 32'(retire), 32'd0);

        // RAW pair: op1=7 followed by op0=7
        a = mk(3'd1, 6'd1, 6'd7);
        b = mk(3'd2, 6'd7, 6'd9);
        cmd_valid = 1'b1;
        cmd_data  = a;
        tick();
        cmd_data = b;
        tick();
        cmd_valid = 1'b0;
        chk_issue("raw.first", a);
`ifdef ISSUE_HAZARD_STALL_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("raw.stall", 32'(stall), 32'd1);
            chk("raw.held", 32'(issue), 32'd0);
        end
        tick();
        chk_issue("raw.second", b);
        chk("raw.retire_same", 32'(retire), 32'd1);
        chk("raw.stall_off", 32'(stall), 32'd0);
`else
        tick();
        chk_issue("raw.second", b);
        chk("raw.stall", 32'(stall), 32'd0);
        chk("raw.inflight", 32'(inflight), 32'd2);
`endif
        repeat (6) tick();
        chk("raw.drained", 32'(inflight), 32'd0);

        // Nine commands with continuous pops: pointer wrap keeps order
        for (int i = 0; i < 11; i++) begin
            if (i < 9) begin
                cmd_valid = 1'b1;
                cmd_data  = stream(i);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 9) begin
                chk_issue($sformatf("stream%0d", i - 1), stream(i - 1));
            end else begin
                chk($sformatf("stream.gap%0d", i), 32'(issue), 32'd0);
            end
            chk($sformatf("stream.count%0d", i), 32'(fifo_count), (i <= 8) ? 32'd1 : 32'd0);
            if (i == 5) begin
                chk("stream.inflight_max", 32'(inflight), 32'd4);
            end
        end
        repeat (6) tick();

        // Flush with a queued entry and a same-cycle push
        w = mk(3'd3, 6'd4, 6'd20);
        x = mk(3'd4, 6'd20, 6'd21);
        y = mk(3'd5, 6'd22, 6'd23);
        cmd_valid = 1'b1;
        cmd_data  = w;
        tick();
        cmd_data = x;
        tick();
        chk_issue("flush.w", w);
        chk("flush.pre_count", 32'(fifo_count), 32'd1);
        flush    = 1'b1;
        cmd_data = y;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush.count", 32'(fifo_count), 32'd0);
        chk("flush.issue", 32'(issue), 32'd0);
        chk("flush.stall", 32'(stall), 32'd0);
        chk("flush.ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("flush.no_issue", 32'(issue), 32'd0);
            chk("flush.retire_wait", 32'(retire), 32'd0);
        end
        tick();
        chk("flush.retire", 32'(retire), 32'd1);
        chk("flush.no_issue_late", 32'(issue), 32'd0);
        chk("flush.count_late", 32'(fifo_count), 32'd0);
        tick();
        chk("flush.retire_off", 32'(retire), 32'd0);
        repeat (4) tick();

`ifdef ISSUE_HAZARD_STALL_EN
        // Fill to DEPTH behind a blocked head; fifth command refused
        begin
            logic [14:0] q [6];
            q[0] = mk(3'd1, 6'd2, 6'd7);
            q[1] = mk(3'd2, 6'd7, 6'd8);
            q[2] = mk(3'd3, 6'd11, 6'd12);
            q[3] = mk(3'd4, 6'd13, 6'd14);
            q[4] = mk(3'd5, 6'd15, 6'd16);
            q[5] = mk(3'd6, 6'd17, 6'd18);
            cmd_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                cmd_data = q[i];
                tick();
            end
            chk("full.count", 32'(fifo_count), 32'd4);
            chk("full.ready", 32'(cmd_ready), 32'd0);
            chk("full.stall", 32'(stall), 32'd1);
            cmd_data = q[5];
            tick();
            cmd_valid = 1'b0;
            chk("full.no_accept", 32'(fifo_count), 32'd3);
            chk_issue("full.drain1", q[1]);
            for (int i = 2; i < 5; i++) begin
                tick();
                chk_issue($sformatf("full.drain%0d", i), q[i]);
            end
            tick();
            chk("full.done", 32'(issue), 32'd0);
            chk("full.empty", 32'(fifo_count), 32'd0);
            repeat (6) tick();
        end
`endif

        // Reset with three commands in flight
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = stream(i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("rstfl.inflight3", 32'(inflight), 32'd3);
        reset = 1'b0;
        #1;
        chk_bubble("rstfl");
        chk("rstfl.inflight", 32'(inflight), 32'd0);
        chk("rstfl.retire", 32'(retire), 32'd0);
        chk("rstfl.count", 32'(fifo_count), 32'd0);
        chk("rstfl.ready", 32'(cmd_ready), 32'd0);
        chk("rstfl.stall", 32'(stall), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rstfl.no_retire%0d", k), 32'(retire), 32'd0);
        end
        chk("rstfl.ready_after", 32'(cmd_ready), 32'd1);
        chk("rstfl.inflight_after", 32'(inflight), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/coproc_issue.md
COPROC_ISSUE -- requirements
Module: coproc_issue

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4: command FIFO entries; power of two, 2..8.
- IDLE_ADDR, 6'd0: reserved scratch register used for bubble slots.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: host command valid.
- cmd_ready, out, 1: FIFO can accept a command.
- cmd_data, in, 15: command word {cmd_id[14:12], op0_id[11:6], op1_id[5:0]}.
- flush, in, 1: synchronous FIFO clear.
- instr, out, 6: op1 and write-back register address to the coprocessor.
- op0_id, out, 6: op0 register address to the coprocessor.
- cmd_id, out, 3: ALU command to the coprocessor.
- issue, out, 1: the current outputs carry a real command.
- retire, out, 1: a previously issued command's result is written back this cycle.
- inflight, out, 3: issued commands not yet retired (0..4).
- fifo_count, out, 4: commands currently buffered.
- stall, out, 1: the FIFO head is blocked by a hazard.

Function
REQ-003 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL equal (fifo_count != DEPTH), and no accept SHALL occur when the FIFO is full, even if a pop happens in the same cycle.
REQ-004 The FIFO SHALL be first-in first-out, with read and write pointers that wrap modulo DEPTH; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-005 instr, op0_id, cmd_id and issue SHALL be registered outputs; a popped command SHALL appear on them for exactly one cycle, on the cycle after the pop edge.
REQ-006 A command pushed at edge N into an empty FIFO SHALL pop no earlier than edge N+1, so issue is first high after edge N+1.
REQ-007 When no command is issued in a cycle, the outputs SHALL be a bubble: instr=IDLE_ADDR, op0_id=IDLE_ADDR, cmd_id=3'b111, issue=0.
REQ-008 A 4-stage valid/address shift register SHALL track issued commands; retire SHALL pulse exactly 4 cycles after the corresponding issue cycle.
REQ-009 inflight SHALL equal the number of set valid bits in the tracker; it SHALL never exceed 4.
REQ-010 The state machine SHALL have the states IDLE (FIFO empty), RUN (popping one command per cycle) and HOLD (head blocked by a hazard); stall SHALL be 1 only in HOLD.
REQ-011 State transitions SHALL be:
- IDLE->RUN when fifo_count becomes nonzero.
- RUN->IDLE when the last entry is popped and no push occurs.
- RUN<->HOLD on the hazard condition of REQ-017.
- HOLD->RUN when the hazard clears.
REQ-012 flush SHALL empty the FIFO and force IDLE at the next edge; flush SHALL take priority over a same-cycle push and pop; in-flight tracking SHALL continue unaffected.

Reset
REQ-013 While reset=0, the FIFO, pointers, tracker and state SHALL clear asynchronously, with the state going to IDLE.
REQ-014 While reset=0, all outputs SHALL be held at: bubble outputs per REQ-007, issue=0, retire=0, inflight=0, fifo_count=0, stall=0, cmd_ready=0.
REQ-015 Retire pulses pending when reset asserts SHALL be discarded and SHALL never be emitted.
REQ-016 Deassertion of reset SHALL take effect at the next rising clk edge; cmd_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-017 With ISSUE_HAZARD_STALL_EN defined, the head SHALL NOT pop while its op0_id or op1_id equals the op1 address of any valid tracker entry (read-after-write hazard); it SHALL stay in HOLD until no match remains.
REQ-018 With ISSUE_HAZARD_STALL_EN undefined, hazard detection SHALL be absent, stall SHALL be tied to 0, and commands SHALL issue back-to-back, relying on coprocessor forwarding.

Verification
REQ-019 Reset release, then push cmd_data=15'h5_0C3 into an empty FIFO:
- issue=1 with cmd_id=5, op0_id=3, instr=3 one cycle after the pop edge.
- retire=1 four cycles later.
REQ-020 Push 4 commands with no pops possible (DEPTH=4):
- cmd_ready=0, fifo_count=4.
- A fifth cmd_valid is not accepted.
- Drain order equals push order.
REQ-021 With ISSUE_HAZARD_STALL_EN defined, push op1=7 followed by op0=7:
- The second command holds with stall=1 for 3 cycles.
- It issues in the same cycle as the first command's retire.
- With the macro undefined, it issues the cycle immediately after the first.
REQ-022 Assert flush with 3 entries queued plus a same-cycle push:
- fifo_count=0 and state IDLE next cycle.
- Already issued commands still retire.
REQ-023 Assert reset with inflight=3: retire never pulses afterwards, inflight=0, outputs show the bubble (IDLE_ADDR, IDLE_ADDR, 3'b111).
REQ-024 Push 9 commands with continuous pops: pointer wrap-around preserves order, and issue is high for 9 consecutive cycles.
